// File: rtl/axi4_lite_control_register_bank.sv
// AXI4-Lite slave bank: PS-writable control words plus PL-driven status words.
// Define RSD_CTRL_REG_SLVERR_EN to answer invalid accesses with SLVERR.
module axi4_lite_control_register_bank #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int WR_REG_NUM = 8,
    parameter int RD_REG_NUM = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [WR_REG_NUM*DATA_WIDTH-1:0] psRegOut,
    output logic [WR_REG_NUM-1:0]          psRegWritten,
    input  logic [RD_REG_NUM*DATA_WIDTH-1:0] plRegIn
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WR_LIM = ADDR_WIDTH'(WR_REG_NUM);
    localparam logic [ADDR_WIDTH-1:0] ALL_LIM = ADDR_WIDTH'(WR_REG_NUM + RD_REG_NUM);
`ifdef RSD_CTRL_REG_SLVERR_EN
    localparam logic [1:0] RESP_ERR = 2'b10;
`else
    localparam logic [1:0] RESP_ERR = 2'b00;
`endif

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wState_e;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rState_e;

    wState_e wState, wNext;
    rState_e rState, rNext;

    logic [DATA_WIDTH-1:0] regs [WR_REG_NUM];
    logic [ADDR_WIDTH-1:0] awAddrQ;
    logic [DATA_WIDTH-1:0] wDataQ;
    logic [STRB_WIDTH-1:0] wStrbQ;
    logic [1:0]            bRespQ;
    logic [1:0]            rRespQ;
    logic [DATA_WIDTH-1:0] rDataQ;
    logic [DATA_WIDTH-1:0] rDataNext;
    logic [WR_REG_NUM-1:0] writtenQ;

    logic                  awHs, wHs, arHs;
    logic                  commit, latchAddr, latchData;
    logic [ADDR_WIDTH-1:0] cAddr, cIdx, arIdx;
    logic [DATA_WIDTH-1:0] cData;
    logic [STRB_WIDTH-1:0] cStrb;
    logic                  cValid, arValid;
    logic                  unusedInputs;

    assign unusedInputs = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = !rst && (wState == W_IDLE || wState == W_HAVE_DATA);
    assign S_AXI_WREADY  = !rst && (wState == W_IDLE || wState == W_HAVE_ADDR);
    assign S_AXI_ARREADY = !rst && (rState == R_IDLE);
    assign S_AXI_BVALID  = (wState == W_RESP);
    assign S_AXI_RVALID  = (rState == R_VALID);
    assign S_AXI_BRESP   = bRespQ;
    assign S_AXI_RRESP   = rRespQ;
    assign S_AXI_RDATA   = rDataQ;
    assign psRegWritten  = writtenQ;

    assign awHs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign wHs  = S_AXI_WVALID && S_AXI_WREADY;
    assign arHs = S_AXI_ARVALID && S_AXI_ARREADY;

    for (genvar g = 0; g < WR_REG_NUM; g++) begin : gOut
        assign psRegOut[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wState <= W_IDLE;
            rState <= R_IDLE;
        end else begin
            wState <= wNext;
            rState <= rNext;
        end
    end

    // Commit operands come from the live bus or from whichever half was latched.
    always_comb begin
        wNext     = wState;
        commit    = 1'b0;
        latchAddr = 1'b0;
        latchData = 1'b0;
        cAddr     = S_AXI_AWADDR;
        cData     = S_AXI_WDATA;
        cStrb     = S_AXI_WSTRB;
        unique case (wState)
            W_IDLE: begin
                if (awHs && wHs) begin
                    commit = 1'b1;
                    wNext  = W_RESP;
                end else if (awHs) begin
                    latchAddr = 1'b1;
                    wNext     = W_HAVE_ADDR;
                end else if (wHs) begin
                    latchData = 1'b1;
                    wNext     = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                cAddr = awAddrQ;
                if (wHs) begin
                    commit = 1'b1;
                    wNext  = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                cData = wDataQ;
                cStrb = wStrbQ;
                if (awHs) begin
                    commit = 1'b1;
                    wNext  = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) wNext = W_IDLE;
            end
            default: wNext = W_IDLE;
        endcase
    end

    always_comb begin
        rNext = rState;
        unique case (rState)
            R_IDLE:  if (arHs) rNext = R_VALID;
            R_VALID: if (S_AXI_RREADY) rNext = R_IDLE;
            default: rNext = R_IDLE;
        endcase
    end

    assign cIdx    = cAddr >> ADDR_LSB;
    assign cValid  = cIdx < WR_LIM;
    assign arIdx   = S_AXI_ARADDR >> ADDR_LSB;
    assign arValid = arIdx < ALL_LIM;

    always_comb begin
        rDataNext = '0;
        for (int i = 0; i < WR_REG_NUM; i++) begin
            if (arIdx == ADDR_WIDTH'(i)) rDataNext = regs[i];
        end
        for (int i = 0; i < RD_REG_NUM; i++) begin
            if (arIdx == ADDR_WIDTH'(WR_REG_NUM + i))
                rDataNext = plRegIn[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awAddrQ  <= '0;
            wDataQ   <= '0;
            wStrbQ   <= '0;
            bRespQ   <= 2'b00;
            rRespQ   <= 2'b00;
            rDataQ   <= '0;
            writtenQ <= '0;
            for (int i = 0; i < WR_REG_NUM; i++) regs[i] <= '0;
        end else begin
            writtenQ <= '0;
            if (latchAddr) awAddrQ <= S_AXI_AWADDR;
            if (latchData) begin
                wDataQ <= S_AXI_WDATA;
                wStrbQ <= S_AXI_WSTRB;
            end
            if (commit) begin
                bRespQ <= cValid ? 2'b00 : RESP_ERR;
                for (int i = 0; i < WR_REG_NUM; i++) begin
                    if (cValid && cIdx == ADDR_WIDTH'(i)) begin
                        writtenQ[i] <= 1'b1;
                        for (int b = 0; b < STRB_WIDTH; b++) begin
                            if (cStrb[b]) regs[i][b*8 +: 8] <= cData[b*8 +: 8];
                        end
                    end
                end
            end
            // Same-edge commit is not visible here: the read sees the old word.
            if (arHs) begin
                rDataQ <= rDataNext;
                rRespQ <= arValid ? 2'b00 : RESP_ERR;
            end
        end
    end

endmodule
